// File: rtl/freq_meter.sv
// Counts synchronised rising edges of freq_in over a GATE_CYCLES window of clk_50MHz, single-shot or continuous.
// Latency: freq_in->rise SYNC_STAGES+1 cycles; count_valid strobes one cycle after the window's last cycle.
// No backpressure: results hold until overwritten. Optional period meter enabled by FREQ_METER_PERIOD_MEAS_EN.
module freq_meter #(
  parameter int unsigned GATE_CYCLES = 50000,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PER_W       = 24
) (
  input  logic             clk_50MHz,
  input  logic             reset,
  input  logic             start,
  input  logic             continuous,
  input  logic             freq_in,
  output logic             busy,
  output logic [CNT_W-1:0] count_out,
  output logic             count_valid,
  output logic             overflow
`ifdef FREQ_METER_PERIOD_MEAS_EN
  ,
  output logic [PER_W-1:0] period_out,
  output logic             period_valid
`endif
);

  localparam int unsigned      GATE_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t                 state_q, state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise;
  logic [GATE_W-1:0]      gate_cnt, gate_nxt;
  logic [CNT_W-1:0]       edge_cnt, edge_nxt, edge_inc;
  logic                   sat, sat_nxt, sat_inc;
  logic [CNT_W-1:0]       count_nxt;
  logic                   ovf_nxt, valid_nxt;

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], freq_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign busy = (state_q == MEASURE);

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      state_q     <= IDLE;
      gate_cnt    <= '0;
      edge_cnt    <= '0;
      sat         <= 1'b0;
      count_out   <= '0;
      overflow    <= 1'b0;
      count_valid <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      gate_cnt    <= gate_nxt;
      edge_cnt    <= edge_nxt;
      sat         <= sat_nxt;
      count_out   <= count_nxt;
      overflow    <= ovf_nxt;
      count_valid <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    gate_nxt  = gate_cnt;
    edge_nxt  = edge_cnt;
    sat_nxt   = sat;
    count_nxt = count_out;
    ovf_nxt   = overflow;
    valid_nxt = 1'b0;
    edge_inc  = edge_cnt;
    sat_inc   = sat;
    if (rise) begin
      if (edge_cnt == CNT_MAX) sat_inc = 1'b1;
      else                     edge_inc = edge_cnt + 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          state_nxt = MEASURE;
          gate_nxt  = '0;
          edge_nxt  = '0;
          sat_nxt   = 1'b0;
        end
      end
      MEASURE: begin
        if (gate_cnt == GATE_LAST) begin
          // The terminal cycle's own rise is folded into the published result.
          count_nxt = edge_inc;
          ovf_nxt   = sat_inc;
          valid_nxt = 1'b1;
          gate_nxt  = '0;
          edge_nxt  = '0;
          sat_nxt   = 1'b0;
          if (!continuous) state_nxt = IDLE;
        end else begin
          gate_nxt = gate_cnt + 1'b1;
          edge_nxt = edge_inc;
          sat_nxt  = sat_inc;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef FREQ_METER_PERIOD_MEAS_EN
  localparam logic [PER_W-1:0] PER_MAX = '1;

  logic [PER_W-1:0] per_cnt;
  logic             per_armed;

  // Free-running; the first rise after reset only arms the measurement.
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      per_cnt      <= '0;
      per_armed    <= 1'b0;
      period_out   <= '0;
      period_valid <= 1'b0;
    end else if (rise) begin
      per_cnt      <= '0;
      period_out   <= (per_cnt == PER_MAX) ? PER_MAX : per_cnt + 1'b1;
      period_valid <= per_armed;
      per_armed    <= 1'b1;
    end else begin
      if (per_cnt != PER_MAX) per_cnt <= per_cnt + 1'b1;
      period_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: three instances (gate 1000, gate 100, gate 100 with 4-bit count) share stimulus.
// A window-level model sums rises over each window's cycle range from a recorded freq_in history.
module tb_freq_meter;

  localparam int MAXE = 40000;

  logic        clk;
  logic        reset, start, continuous, freq_in;
  logic [2:0]  busy_v, cv_v, ovf_v;
  logic [15:0] cnt_a, cnt_b;
  logic [3:0]  cnt_s;
  logic [15:0] cnt_v [3];
`ifdef FREQ_METER_PERIOD_MEAS_EN
  logic [23:0] period_out;
  logic        period_valid;
`endif

  assign cnt_v[0] = cnt_a;
  assign cnt_v[1] = cnt_b;
  assign cnt_v[2] = {12'd0, cnt_s};

  freq_meter #(.GATE_CYCLES(1000), .CNT_W(16)) u_g1000 (
    .clk_50MHz(clk), .reset(reset), .start(start), .continuous(continuous), .freq_in(freq_in),
    .busy(busy_v[0]), .count_out(cnt_a), .count_valid(cv_v[0]), .overflow(ovf_v[0]));

  freq_meter #(.GATE_CYCLES(100), .CNT_W(16)) u_g100 (
    .clk_50MHz(clk), .reset(reset), .start(start), .continuous(continuous), .freq_in(freq_in),
    .busy(busy_v[1]), .count_out(cnt_b), .count_valid(cv_v[1]), .overflow(ovf_v[1])
`ifdef FREQ_METER_PERIOD_MEAS_EN
    , .period_out(period_out), .period_valid(period_valid)
`endif
  );

  freq_meter #(.GATE_CYCLES(100), .CNT_W(4)) u_sat (
    .clk_50MHz(clk), .reset(reset), .start(start), .continuous(continuous), .freq_in(freq_in),
    .busy(busy_v[2]), .count_out(cnt_s), .count_valid(cv_v[2]), .overflow(ovf_v[2]));

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int vectors = 0;
  int fails   = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  // freq_in generator: f_hi==0 holds low, f_lo==0 holds high, else f_hi cycles high / f_lo low.
  int f_hi = 2, f_lo = 2;
  initial begin
    int ph;
    ph = 0;
    freq_in = 1'b0;
    forever begin
      @(negedge clk);
      if (f_hi == 0) freq_in = 1'b0;
      else if (f_lo == 0) freq_in = 1'b1;
      else begin
        ph++;
        if (freq_in && ph >= f_hi) begin freq_in = 1'b0; ph = 0; end
        else if (!freq_in && ph >= f_lo) begin freq_in = 1'b1; ph = 0; end
      end
    end
  end

  // Reference model: hist[e] is freq_in as seen at edge e; a rise is used at edge e when
  // freq_in went 0->1 between edges e-3 and e-2. Windows are [ws, ws+G-1] in edge numbers.
  bit hist [MAXE];
  int ecnt = 0;
  int G  [3] = '{1000, 100, 100};
  int MX [3] = '{65535, 65535, 15};
  bit m_busy [3];
  bit m_cv   [3];
  bit m_ovf  [3];
  int m_cnt  [3];
  int m_ws   [3];
  bit chk_en = 1'b0;

  function automatic int rises(input int a, input int b);
    int s = 0;
    for (int i = a; i <= b; i++)
      if (i >= 3 && hist[i-2] && !hist[i-3]) s++;
    return s;
  endfunction

`ifdef FREQ_METER_PERIOD_MEAS_EN
  bit p_armed, m_pv;
  int p_last, m_po;
`endif

  always @(posedge clk) begin
    ecnt <= ecnt + 1;
    hist[ecnt] <= freq_in;
    if (reset) begin
      hist[ecnt] <= 1'b0;
      if (ecnt >= 2) begin hist[ecnt-1] <= 1'b0; hist[ecnt-2] <= 1'b0; end
      for (int i = 0; i < 3; i++) begin
        m_busy[i] <= 1'b0; m_cv[i] <= 1'b0; m_ovf[i] <= 1'b0; m_cnt[i] <= 0;
      end
`ifdef FREQ_METER_PERIOD_MEAS_EN
      p_armed <= 1'b0; m_pv <= 1'b0;
`endif
    end else begin
      for (int i = 0; i < 3; i++) begin
        m_cv[i] <= 1'b0;
        if (!m_busy[i]) begin
          if (start) begin m_busy[i] <= 1'b1; m_ws[i] <= ecnt + 1; end
        end else if (ecnt == m_ws[i] + G[i] - 1) begin
          m_cnt[i] <= (rises(m_ws[i], ecnt) > MX[i]) ? MX[i] : rises(m_ws[i], ecnt);
          m_ovf[i] <= (rises(m_ws[i], ecnt) > MX[i]);
          m_cv[i]  <= 1'b1;
          if (continuous) m_ws[i] <= ecnt + 1;
          else            m_busy[i] <= 1'b0;
        end
      end
`ifdef FREQ_METER_PERIOD_MEAS_EN
      if (rises(ecnt, ecnt) == 1) begin
        m_pv <= p_armed;
        if (p_armed) m_po <= ecnt - p_last;
        p_armed <= 1'b1;
        p_last  <= ecnt;
      end else m_pv <= 1'b0;
`endif
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++)
        check($sformatf("cycle%0d_inst%0d", ecnt, i),
              {busy_v[i], cv_v[i], ovf_v[i], cnt_v[i]},
              {m_busy[i], m_cv[i], m_ovf[i], 16'(m_cnt[i])});
`ifdef FREQ_METER_PERIOD_MEAS_EN
      check($sformatf("period_valid%0d", ecnt), period_valid, m_pv);
      if (m_pv) check($sformatf("period_out%0d", ecnt), period_out, m_po);
`endif
    end
  end

  typedef struct {
    int hi;
    int lo;
    int inst;
    int exp_cnt;
    bit exp_ovf;
    int exp_lat;
  } vec_t;

  vec_t tab [6];

  task automatic wait_idle();
    continuous = 1'b0;
    for (int c = 0; c < 3000 && busy_v != 3'b000; c++) @(negedge clk);
    check("idle_timeout", busy_v, 3'b000);
  endtask

  initial begin
    int nstrobe, lat, got, ns, sum;
    int stamps [5];

    tab[0] = '{25, 25, 0, 20, 1'b0, 1001};
    tab[1] = '{ 0,  0, 1,  0, 1'b0,  101};
    tab[2] = '{ 1,  0, 1,  0, 1'b0,  101};
    tab[3] = '{ 2,  2, 2, 15, 1'b1,  101};
    tab[4] = '{ 5,  5, 2, 10, 1'b0,  101};
    tab[5] = '{ 5,  5, 1, 10, 1'b0,  101};

    reset = 1'b1; start = 1'b0; continuous = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      check($sformatf("reset_state_inst%0d", i), {busy_v[i], cv_v[i], ovf_v[i], cnt_v[i]}, 19'd0);
    chk_en = 1'b1;
    reset = 1'b0;

    nstrobe = 0;
    repeat (2000) begin
      @(negedge clk);
      if (cv_v != 3'b000) nstrobe++;
    end
    check("no_strobe_without_start", nstrobe, 0);

    for (int t = 0; t < 6; t++) begin
      f_hi = tab[t].hi; f_lo = tab[t].lo;
      repeat (20) @(negedge clk);
      start = 1'b1;
      got = 0; lat = 0;
      for (int c = 1; c <= 1200 && got == 0; c++) begin
        @(negedge clk);
        start = 1'b0;
        if (cv_v[tab[t].inst]) begin got = 1; lat = c; end
      end
      check($sformatf("tab%0d_latency", t), got ? lat : -1, tab[t].exp_lat);
      check($sformatf("tab%0d_count", t), cnt_v[tab[t].inst], tab[t].exp_cnt);
      check($sformatf("tab%0d_overflow", t), ovf_v[tab[t].inst], tab[t].exp_ovf);
      check($sformatf("tab%0d_back_to_idle", t), busy_v[tab[t].inst], 1'b0);
      wait_idle();
    end

    // Reset in the middle of a window: no strobe, results cleared.
    f_hi = 5; f_lo = 5;
    repeat (10) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (49) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_busy", busy_v, 3'b000);
    check("midreset_count", cnt_b, 16'd0);
    nstrobe = 0;
    repeat (150) begin
      @(negedge clk);
      if (cv_v[1]) nstrobe++;
    end
    check("midreset_no_strobe", nstrobe, 0);

    // Continuous mode, period 7, with ignored start pulses while busy.
    f_hi = 3; f_lo = 4;
    repeat (10) @(negedge clk);
    continuous = 1'b1;
    start = 1'b1;
    ns = 0; sum = 0;
    for (int c = 0; c < 800 && ns < 5; c++) begin
      @(negedge clk);
      start = (c % 13 == 5);
      if (cv_v[1]) begin stamps[ns] = ecnt; sum += cnt_b; ns++; end
    end
    start = 1'b0;
    check("cont_strobe_count", ns, 5);
    for (int j = 1; j < 5; j++)
      check($sformatf("cont_spacing%0d", j), (ns == 5) ? stamps[j] - stamps[j-1] : -1, 100);
    if (ns == 5) check("cont_sum", sum, rises(stamps[0] - 100, stamps[4] - 1));
    wait_idle();

    // Randomised traffic against the model.
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if (c % 200 == 0) begin
        if ($urandom_range(0, 7) == 0) begin f_hi = $urandom_range(0, 1); f_lo = 0; end
        else begin f_hi = $urandom_range(2, 9); f_lo = $urandom_range(2, 9); end
      end
      start = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 149) == 0) continuous = ~continuous;
      reset = ($urandom_range(0, 699) == 0);
    end
    reset = 1'b0; start = 1'b0;
    wait_idle();
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
